// File: rtl/sync_edge_monitor.sv
// rtl/sync_edge_monitor.sv - receive-side sync monitor: synchronise, detect edges, measure interval, track lock
module sync_edge_monitor #(
  parameter int FREQ_CLK   = 25000000,
  parameter int TOL        = 250,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             syncin,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic [15:0]      edge_count,
  output logic [15:0]      error_count
);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, LOST} state_t;

  localparam logic [CNT_W-1:0] IV_LO       = CNT_W'(FREQ_CLK - TOL);
  localparam logic [CNT_W-1:0] IV_HI       = CNT_W'(FREQ_CLK + TOL);
  localparam logic [CNT_W-1:0] IV_TIMEOUT  = CNT_W'(FREQ_CLK + TOL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam int               GW          = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0]    GOOD_TARGET = GW'(LOCK_COUNT);

  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  state_t           state, state_next;
  logic [GW-1:0]    good_cnt, good_cnt_next;
  logic             err_inc;
  logic             measuring;
  logic             good_iv;
  logic             timeout;

  assign measuring = (state == ARMED) || (state == LOCKED);
  assign good_iv   = (cnt >= IV_LO) && (cnt <= IV_HI);
  assign timeout   = measuring && (cnt == IV_TIMEOUT);

  // Pulses alongside edge_pulse; period carries the new value from the next cycle.
  assign period_valid = edge_pulse && enable && measuring;

  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    err_inc       = 1'b0;
    if (!enable) begin
      state_next    = IDLE;
      good_cnt_next = '0;
    end else if (edge_pulse) begin
      // An edge coinciding with the timeout cycle is judged as an interval.
      case (state)
        IDLE, LOST: begin
          state_next    = ARMED;
          good_cnt_next = '0;
        end
        ARMED: begin
          if (good_iv) begin
            good_cnt_next = good_cnt + GW'(1);
            if (good_cnt + GW'(1) == GOOD_TARGET) state_next = LOCKED;
          end else begin
            good_cnt_next = '0;
          end
        end
        LOCKED: begin
          if (!good_iv) begin
            state_next    = ARMED;
            good_cnt_next = '0;
            err_inc       = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      state_next = LOST;
      err_inc    = (state == LOCKED);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      edge_pulse  <= 1'b0;
      cnt         <= '0;
      period      <= '0;
      state       <= IDLE;
      good_cnt    <= '0;
      locked      <= 1'b0;
      lost        <= 1'b0;
      edge_count  <= '0;
      error_count <= '0;
    end else begin
      s1         <= syncin;
      s2         <= s1;
      s3         <= s2;
      edge_pulse <= s2 ^ s3;

      if (edge_pulse)          cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);

      if (period_valid) period <= cnt;

      state    <= state_next;
      good_cnt <= good_cnt_next;
      locked   <= (state_next == LOCKED);
      lost     <= (state_next == LOST);

      if (enable && edge_pulse && edge_count != 16'hFFFF)
        edge_count <= edge_count + 16'd1;
      if (err_inc && error_count != 16'hFFFF)
        error_count <= error_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sync_edge_monitor.sv
// tb/tb_sync_edge_monitor.sv - directed and randomized bench for sync_edge_monitor
module tb_sync_edge_monitor;

  localparam int F      = 100;
  localparam int T      = 2;
  localparam int LC     = 3;
  localparam int W      = 32;
  localparam int IV_LO  = F - T;
  localparam int IV_HI  = F + T;
  localparam int M_IDLE   = 0;
  localparam int M_ARMED  = 1;
  localparam int M_LOCKED = 2;
  localparam int M_LOST   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          syncin = 1'b0;
  logic          edge_pulse;
  logic [W-1:0]  period;
  logic          period_valid;
  logic          locked;
  logic          lost;
  logic [15:0]   edge_count;
  logic [15:0]   error_count;

  int n_checks = 0;
  int n_fail   = 0;

  int   m_state, m_good, m_period, m_edges, m_errors;
  logic m_pv;
  int   since;

  sync_edge_monitor #(
    .FREQ_CLK(F), .TOL(T), .LOCK_COUNT(LC), .CNT_W(W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .syncin(syncin),
    .edge_pulse(edge_pulse), .period(period), .period_valid(period_valid),
    .locked(locked), .lost(lost), .edge_count(edge_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = M_IDLE;
    m_good   = 0;
    m_period = 0;
    m_edges  = 0;
    m_errors = 0;
    m_pv     = 1'b0;
  endtask

  // Applies one edge arriving n cycles after the previous one.
  task automatic model_edge(input int n);
    logic meas, good;
    m_pv = 1'b0;
    if (!enable) begin
      m_state = M_IDLE;
      m_good  = 0;
      return;
    end
    if (m_edges < 65535) m_edges++;
    if ((m_state == M_ARMED || m_state == M_LOCKED) && n > IV_HI + 1) begin
      if (m_state == M_LOCKED) m_errors++;
      m_state = M_LOST;
    end
    meas = (m_state == M_ARMED || m_state == M_LOCKED);
    good = (n >= IV_LO) && (n <= IV_HI);
    m_pv = meas;
    if (meas) m_period = n;
    case (m_state)
      M_IDLE, M_LOST: begin
        m_state = M_ARMED;
        m_good  = 0;
      end
      M_ARMED: begin
        if (good) begin
          m_good++;
          if (m_good == LC) m_state = M_LOCKED;
        end else begin
          m_good = 0;
        end
      end
      default: begin
        if (!good) begin
          m_state = M_ARMED;
          m_good  = 0;
          if (m_errors < 65535) m_errors++;
        end
      end
    endcase
  endtask

  task automatic pulse_edge(input int n);
    repeat (n - since) @(posedge clk);
    #1 syncin = ~syncin;
    repeat (3) @(posedge clk);
    #1;
    model_edge(n);
    check("edge_pulse", 32'(edge_pulse), 32'd1);
    check("period_valid", 32'(period_valid), 32'(m_pv));
    @(posedge clk);
    #1;
    check("period", period, 32'(m_period));
    check("locked", 32'(locked), 32'(m_state == M_LOCKED));
    check("lost", 32'(lost), 32'(m_state == M_LOST));
    check("edge_count", 32'(edge_count), 32'(m_edges));
    check("error_count", 32'(error_count), 32'(m_errors));
    since = 4;
  endtask

  initial begin
    int n, r, pulses, p_hold;
    model_reset();
    since = 0;

    // 1: reset held with syncin toggling
    reset  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      syncin = ~syncin;
      check("rst_edge_pulse", 32'(edge_pulse), 32'd0);
      check("rst_period_valid", 32'(period_valid), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_lost", 32'(lost), 32'd0);
      check("rst_period", period, 32'd0);
      check("rst_edge_count", 32'(edge_count), 32'd0);
      check("rst_error_count", 32'(error_count), 32'd0);
    end
    syncin = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b1;
    since  = 0;

    // 2: nominal toggling locks after the 4th edge
    pulse_edge(20);
    for (int i = 0; i < 3; i++) pulse_edge(F);
    check("t2_locked", 32'(locked), 32'd1);
    check("t2_edge_count", 32'(edge_count), 32'd4);
    check("t2_period", period, 32'd100);
    check("t2_error_count", 32'(error_count), 32'd0);

    // 3: tolerance boundaries, then relock
    pulse_edge(98);
    pulse_edge(102);
    check("t3_locked_in_tol", 32'(locked), 32'd1);
    pulse_edge(103);
    check("t3_unlocked", 32'(locked), 32'd0);
    check("t3_error_count", 32'(error_count), 32'd1);
    for (int i = 0; i < 3; i++) pulse_edge(F);
    check("t3_relocked", 32'(locked), 32'd1);

    // randomized intervals: good, short, boundary-long and timeout
    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)      n = int'($urandom_range(88, 97));
      else if (r == 1) n = int'($urandom_range(103, 130));
      else             n = int'($urandom_range(98, 102));
      pulse_edge(n);
    end
    for (int i = 0; i < 4; i++) pulse_edge(F);
    check("rand_relocked", 32'(locked), 32'd1);

    // 4: syncin stops while locked
    for (int i = 0; i < IV_HI; i++) begin
      @(posedge clk);
      #1;
      check("t4_not_lost_yet", 32'(lost), 32'd0);
    end
    @(posedge clk);
    #1;
    m_state = M_LOST;
    m_errors++;
    check("t4_lost", 32'(lost), 32'd1);
    check("t4_locked", 32'(locked), 32'd0);
    check("t4_error_count", 32'(error_count), 32'(m_errors));
    since += IV_HI + 1;
    p_hold = m_period;
    pulse_edge(since + 50);
    check("t4_rearmed", 32'(lost), 32'd0);
    check("t4_period_kept", period, 32'(p_hold));
    for (int i = 0; i < 3; i++) pulse_edge(F);
    check("t4_relocked", 32'(locked), 32'd1);

    // 5: enable dropped while locked
    enable = 1'b0;
    @(posedge clk);
    #1;
    since++;
    m_state = M_IDLE;
    m_good  = 0;
    check("t5_locked_drop", 32'(locked), 32'd0);
    pulse_edge(F);
    pulse_edge(F);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) pulse_edge(F);
    check("t5_not_locked_after_3", 32'(locked), 32'd0);
    pulse_edge(F);
    check("t5_locked_after_4", 32'(locked), 32'd1);

    // 6: reset pulse while locked, then glitches
    if (syncin) pulse_edge(F);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("t6_period", period, 32'd0);
    check("t6_edge_count", 32'(edge_count), 32'd0);
    check("t6_error_count", 32'(error_count), 32'd0);
    check("t6_locked", 32'(locked), 32'd0);
    check("t6_lost", 32'(lost), 32'd0);

    @(posedge clk);
    #1 syncin = 1'b1;
    #3 syncin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("t6_narrow_glitch", 32'(edge_pulse), 32'd0);
    end

    pulses = 0;
    @(posedge clk);
    #1 syncin = 1'b1;
    @(posedge clk);
    #1 syncin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (edge_pulse === 1'b1) pulses++;
      else if (edge_pulse !== 1'b0) pulses += 100;
    end
    check("t6_wide_glitch_pulses", 32'(pulses), 32'd2);
    check("t6_wide_glitch_edges", 32'(edge_count), 32'd2);
    check("t6_wide_glitch_locked", 32'(locked), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
